// File: rtl/idex_hazard_reg_if.sv
// ID/EX boundary bundle: decode-side inputs, registered ID/EX fields
// and the hazard enables returned to fetch/decode.
interface idex_hazard_reg_if;
  logic [4:0]  IFID_RegisterRs;
  logic [4:0]  IFID_RegisterRt;
  logic [4:0]  IFID_RegisterRd;
  logic [31:0] ID_ReadData1;
  logic [31:0] ID_ReadData2;
  logic [31:0] ID_Imm;
  logic        ID_RegWrite;
  logic        ID_MemRead;
  logic        ID_MemWrite;
  logic        ID_MemtoReg;
  logic        ID_RegDst;
  logic        ID_ALUSrc;
  logic [1:0]  ID_ALUOp;
  logic        ID_UsesRt;
  logic        flush;
  logic        mem_busy;
  // Test/debug preload of the stall counter.
  logic        sc_load;
  logic [15:0] sc_load_val;

  logic [4:0]  IDEX_RegisterRs;
  logic [4:0]  IDEX_RegisterRt;
  logic [4:0]  IDEX_RegisterRd;
  logic [31:0] IDEX_ReadData1;
  logic [31:0] IDEX_ReadData2;
  logic [31:0] IDEX_Imm;
  logic        IDEX_RegWrite;
  logic        IDEX_MemRead;
  logic        IDEX_MemWrite;
  logic        IDEX_MemtoReg;
  logic        IDEX_RegDst;
  logic        IDEX_ALUSrc;
  logic [1:0]  IDEX_ALUOp;
  logic        PCWrite;
  logic        IFID_Write;
  logic        stall;
  logic [15:0] stall_count;

  modport master (
    output IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd,
    output ID_ReadData1, ID_ReadData2, ID_Imm,
    output ID_RegWrite, ID_MemRead, ID_MemWrite,
    output ID_MemtoReg, ID_RegDst, ID_ALUSrc,
    output ID_ALUOp, ID_UsesRt, flush, mem_busy,
    output sc_load, sc_load_val,
    input  IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd,
    input  IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
    input  IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite,
    input  IDEX_MemtoReg, IDEX_RegDst, IDEX_ALUSrc,
    input  IDEX_ALUOp, PCWrite, IFID_Write, stall, stall_count
  );

  modport slave (
    input  IFID_RegisterRs, IFID_RegisterRt, IFID_RegisterRd,
    input  ID_ReadData1, ID_ReadData2, ID_Imm,
    input  ID_RegWrite, ID_MemRead, ID_MemWrite,
    input  ID_MemtoReg, ID_RegDst, ID_ALUSrc,
    input  ID_ALUOp, ID_UsesRt, flush, mem_busy,
    input  sc_load, sc_load_val,
    output IDEX_RegisterRs, IDEX_RegisterRt, IDEX_RegisterRd,
    output IDEX_ReadData1, IDEX_ReadData2, IDEX_Imm,
    output IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite,
    output IDEX_MemtoReg, IDEX_RegDst, IDEX_ALUSrc,
    output IDEX_ALUOp, PCWrite, IFID_Write, stall, stall_count
  );
endinterface

// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection,
// flush/freeze handling and a saturating stall counter.
module idex_hazard_reg (
  input logic         clk,
  input logic         reset,
  idex_hazard_reg_if.slave bus
);

  typedef enum logic [1:0] {
    M_LOAD,
    M_BUBBLE,
    M_FLUSH,
    M_HOLD
  } mode_e;

  mode_e mode;
  logic  rs_hit;
  logic  rt_hit;
  logic  load_use;
  logic  sel_hold;
  logic  sel_flush;
  logic  sel_bubble;

  assign rs_hit = bus.IDEX_RegisterRt == bus.IFID_RegisterRs;
  assign rt_hit = bus.ID_UsesRt &&
                  (bus.IDEX_RegisterRt == bus.IFID_RegisterRt);

  assign load_use = bus.IDEX_MemRead &&
                    (bus.IDEX_RegisterRt != 5'd0) &&
                    (rs_hit || rt_hit);

  // Mutually exclusive selects encode the priority order;
  // reset forces the pass-through enables.
  assign sel_hold   = !reset && bus.mem_busy;
  assign sel_flush  = !reset && !bus.mem_busy && bus.flush;
  assign sel_bubble = !reset && !bus.mem_busy && !bus.flush &&
                      load_use;

  always_comb begin
    mode = M_LOAD;
    unique case (1'b1)
      sel_hold:   mode = M_HOLD;
      sel_flush:  mode = M_FLUSH;
      sel_bubble: mode = M_BUBBLE;
      default:    mode = M_LOAD;
    endcase
  end

  always_comb begin
    bus.PCWrite    = 1'b1;
    bus.IFID_Write = 1'b1;
    bus.stall      = 1'b0;
    unique case (mode)
      M_HOLD: begin
        bus.PCWrite    = 1'b0;
        bus.IFID_Write = 1'b0;
      end
      M_BUBBLE: begin
        bus.PCWrite    = 1'b0;
        bus.IFID_Write = 1'b0;
        bus.stall      = 1'b1;
      end
      default: begin
        bus.PCWrite    = 1'b1;
        bus.IFID_Write = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.IDEX_RegisterRs <= '0;
      bus.IDEX_RegisterRt <= '0;
      bus.IDEX_RegisterRd <= '0;
      bus.IDEX_ReadData1  <= '0;
      bus.IDEX_ReadData2  <= '0;
      bus.IDEX_Imm        <= '0;
      bus.IDEX_RegWrite   <= 1'b0;
      bus.IDEX_MemRead    <= 1'b0;
      bus.IDEX_MemWrite   <= 1'b0;
      bus.IDEX_MemtoReg   <= 1'b0;
      bus.IDEX_RegDst     <= 1'b0;
      bus.IDEX_ALUSrc     <= 1'b0;
      bus.IDEX_ALUOp      <= '0;
    end else begin
      unique case (mode)
        M_LOAD: begin
          bus.IDEX_RegisterRs <= bus.IFID_RegisterRs;
          bus.IDEX_RegisterRt <= bus.IFID_RegisterRt;
          bus.IDEX_RegisterRd <= bus.IFID_RegisterRd;
          bus.IDEX_ReadData1  <= bus.ID_ReadData1;
          bus.IDEX_ReadData2  <= bus.ID_ReadData2;
          bus.IDEX_Imm        <= bus.ID_Imm;
          bus.IDEX_RegWrite   <= bus.ID_RegWrite;
          bus.IDEX_MemRead    <= bus.ID_MemRead;
          bus.IDEX_MemWrite   <= bus.ID_MemWrite;
          bus.IDEX_MemtoReg   <= bus.ID_MemtoReg;
          bus.IDEX_RegDst     <= bus.ID_RegDst;
          bus.IDEX_ALUSrc     <= bus.ID_ALUSrc;
          bus.IDEX_ALUOp      <= bus.ID_ALUOp;
        end
        M_BUBBLE, M_FLUSH: begin
          bus.IDEX_RegisterRs <= '0;
          bus.IDEX_RegisterRt <= '0;
          bus.IDEX_RegisterRd <= '0;
          bus.IDEX_ReadData1  <= '0;
          bus.IDEX_ReadData2  <= '0;
          bus.IDEX_Imm        <= '0;
          bus.IDEX_RegWrite   <= 1'b0;
          bus.IDEX_MemRead    <= 1'b0;
          bus.IDEX_MemWrite   <= 1'b0;
          bus.IDEX_MemtoReg   <= 1'b0;
          bus.IDEX_RegDst     <= 1'b0;
          bus.IDEX_ALUSrc     <= 1'b0;
          bus.IDEX_ALUOp      <= '0;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stall_count <= '0;
    end else if (bus.sc_load) begin
      bus.stall_count <= bus.sc_load_val;
    end else if ((mode == M_BUBBLE) &&
                 (bus.stall_count != 16'hFFFF)) begin
      bus.stall_count <= bus.stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed and randomized checks of idex_hazard_reg against
// a cycle-level behavioural model of the ID/EX hazard rules.
module tb_idex_hazard_reg;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        m2r;
    logic        rdst;
    logic        asrc;
    logic [1:0]  op;
  } ex_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  ex_t  m_ex;
  int   m_cnt;

  always #5 clk = ~clk;

  idex_hazard_reg_if bus ();

  idex_hazard_reg dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic ex_t out_bundle();
    ex_t v;
    v.rs   = bus.IDEX_RegisterRs;
    v.rt   = bus.IDEX_RegisterRt;
    v.rd   = bus.IDEX_RegisterRd;
    v.d1   = bus.IDEX_ReadData1;
    v.d2   = bus.IDEX_ReadData2;
    v.imm  = bus.IDEX_Imm;
    v.rw   = bus.IDEX_RegWrite;
    v.mr   = bus.IDEX_MemRead;
    v.mw   = bus.IDEX_MemWrite;
    v.m2r  = bus.IDEX_MemtoReg;
    v.rdst = bus.IDEX_RegDst;
    v.asrc = bus.IDEX_ALUSrc;
    v.op   = bus.IDEX_ALUOp;
    return v;
  endfunction

  function automatic ex_t in_bundle();
    ex_t v;
    v.rs   = bus.IFID_RegisterRs;
    v.rt   = bus.IFID_RegisterRt;
    v.rd   = bus.IFID_RegisterRd;
    v.d1   = bus.ID_ReadData1;
    v.d2   = bus.ID_ReadData2;
    v.imm  = bus.ID_Imm;
    v.rw   = bus.ID_RegWrite;
    v.mr   = bus.ID_MemRead;
    v.mw   = bus.ID_MemWrite;
    v.m2r  = bus.ID_MemtoReg;
    v.rdst = bus.ID_RegDst;
    v.asrc = bus.ID_ALUSrc;
    v.op   = bus.ID_ALUOp;
    return v;
  endfunction

  task automatic drive(input ex_t v, input bit uses_rt);
    bus.IFID_RegisterRs = v.rs;
    bus.IFID_RegisterRt = v.rt;
    bus.IFID_RegisterRd = v.rd;
    bus.ID_ReadData1    = v.d1;
    bus.ID_ReadData2    = v.d2;
    bus.ID_Imm          = v.imm;
    bus.ID_RegWrite     = v.rw;
    bus.ID_MemRead      = v.mr;
    bus.ID_MemWrite     = v.mw;
    bus.ID_MemtoReg     = v.m2r;
    bus.ID_RegDst       = v.rdst;
    bus.ID_ALUSrc       = v.asrc;
    bus.ID_ALUOp        = v.op;
    bus.ID_UsesRt       = uses_rt;
  endtask

  function automatic ex_t mk(input int rs, input int rt,
                             input bit load, input int imm);
    ex_t v;
    v      = '0;
    v.rs   = rs[4:0];
    v.rt   = rt[4:0];
    v.rd   = 5'(rt + 1);
    v.d1   = 32'hA000_0000 + rs;
    v.d2   = 32'hB000_0000 + rt;
    v.imm  = imm;
    v.rw   = 1'b1;
    v.mr   = load;
    v.m2r  = load;
    v.asrc = load;
    v.rdst = !load;
    v.op   = load ? 2'b00 : 2'b10;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Load-use rule evaluated on the model's ID/EX contents.
  function automatic bit m_hazard();
    bit src;
    src = (m_ex.rt == bus.IFID_RegisterRs) ||
          (bus.ID_UsesRt && (m_ex.rt == bus.IFID_RegisterRt));
    return m_ex.mr && (m_ex.rt != 0) && src;
  endfunction

  // Called at a falling edge with inputs applied: checks the
  // same-cycle enables, crosses one rising edge, checks state.
  task automatic cycle();
    bit   hz;
    bit   e_pc;
    bit   e_st;
    ex_t  n_ex;
    int   n_cnt;
    #1;
    hz    = m_hazard();
    n_ex  = m_ex;
    n_cnt = m_cnt;
    e_pc  = 1'b1;
    e_st  = 1'b0;
    if (bus.mem_busy) begin
      e_pc = 1'b0;
    end else if (bus.flush) begin
      n_ex = '0;
    end else if (hz) begin
      e_pc  = 1'b0;
      e_st  = 1'b1;
      n_ex  = '0;
      n_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
    end else begin
      n_ex = in_bundle();
    end
    if (bus.sc_load) n_cnt = int'(bus.sc_load_val);
    chk("pcwrite", 128'(bus.PCWrite), 128'(e_pc));
    chk("ifid_write", 128'(bus.IFID_Write), 128'(e_pc));
    chk("stall", 128'(bus.stall), 128'(e_st));
    @(posedge clk);
    m_ex  = n_ex;
    m_cnt = n_cnt;
    @(negedge clk);
    chk("idex", 128'(out_bundle()), 128'(m_ex));
    chk("stall_count", 128'(bus.stall_count), 128'(m_cnt));
  endtask

  ex_t r;
  int  saved;

  initial begin
    reset           = 1'b1;
    bus.flush       = 1'b0;
    bus.mem_busy    = 1'b0;
    bus.sc_load     = 1'b0;
    bus.sc_load_val = '0;
    drive('0, 1'b0);
    m_ex  = '0;
    m_cnt = 0;
    #2;
    chk("rst_idex", 128'(out_bundle()), 128'(0));
    chk("rst_cnt", 128'(bus.stall_count), 128'(0));
    chk("rst_pcwrite", 128'(bus.PCWrite), 128'(1));
    chk("rst_stall", 128'(bus.stall), 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // lw $5 followed by a dependent add
    drive(mk(2, 5, 1'b1, 32'h10), 1'b0);
    cycle();
    drive(mk(5, 6, 1'b0, 32'h0), 1'b1);
    #1;
    chk("lu_stall", 128'(bus.stall), 128'(1));
    chk("lu_pcwrite", 128'(bus.PCWrite), 128'(0));
    cycle();
    chk("lu_bubble", 128'(out_bundle()), 128'(0));
    chk("lu_cnt", 128'(bus.stall_count), 128'(1));
    cycle();
    chk("lu_resume_rs", 128'(bus.IDEX_RegisterRs), 128'(5));

    // Rt dependence only counts when the instruction reads Rt
    drive(mk(1, 7, 1'b1, 32'h20), 1'b0);
    cycle();
    drive(mk(1, 7, 1'b0, 32'h0), 1'b0);
    #1;
    chk("rt_nouse", 128'(bus.stall), 128'(0));
    cycle();
    drive(mk(1, 7, 1'b1, 32'h24), 1'b0);
    cycle();
    drive(mk(1, 7, 1'b0, 32'h0), 1'b1);
    #1;
    chk("rt_use", 128'(bus.stall), 128'(1));
    cycle();
    cycle();

    // load into $0 never stalls
    drive(mk(3, 0, 1'b1, 32'h30), 1'b0);
    cycle();
    drive(mk(0, 0, 1'b0, 32'h34), 1'b1);
    #1;
    chk("r0_stall", 128'(bus.stall), 128'(0));
    cycle();
    chk("r0_load", 128'(bus.IDEX_Imm), 128'(32'h34));

    // flush beats a pending load-use
    drive(mk(1, 9, 1'b1, 32'h40), 1'b0);
    cycle();
    saved = m_cnt;
    drive(mk(9, 2, 1'b0, 32'h44), 1'b1);
    bus.flush = 1'b1;
    #1;
    chk("fl_pcwrite", 128'(bus.PCWrite), 128'(1));
    cycle();
    bus.flush = 1'b0;
    chk("fl_idex", 128'(out_bundle()), 128'(0));
    chk("fl_cnt", 128'(bus.stall_count), 128'(saved));

    // memory freeze holds ID/EX for three cycles
    drive(mk(4, 8, 1'b0, 32'h1234), 1'b0);
    cycle();
    drive(mk(6, 6, 1'b0, 32'h5678), 1'b0);
    bus.mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mb_pcwrite", 128'(bus.PCWrite), 128'(0));
      cycle();
      chk("mb_imm", 128'(bus.IDEX_Imm), 128'(32'h1234));
      chk("mb_rw", 128'(bus.IDEX_RegWrite), 128'(1));
    end
    bus.mem_busy = 1'b0;
    cycle();
    chk("mb_resume", 128'(bus.IDEX_Imm), 128'(32'h5678));

    // freeze during a pending hazard defers the bubble
    drive(mk(1, 3, 1'b1, 32'h50), 1'b0);
    cycle();
    drive(mk(3, 1, 1'b0, 32'h54), 1'b1);
    bus.mem_busy = 1'b1;
    cycle();
    cycle();
    bus.mem_busy = 1'b0;
    #1;
    chk("mb_hz_stall", 128'(bus.stall), 128'(1));
    cycle();
    cycle();

    // saturation from a preloaded counter
    bus.sc_load     = 1'b1;
    bus.sc_load_val = 16'hFFFE;
    drive(mk(1, 2, 1'b0, 32'h60), 1'b0);
    cycle();
    bus.sc_load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(mk(1, 4, 1'b1, 32'h64), 1'b0);
      cycle();
      drive(mk(4, 2, 1'b0, 32'h68), 1'b0);
      cycle();
    end
    chk("sat_cnt", 128'(bus.stall_count), 128'(16'hFFFF));

    // asynchronous reset in the middle of a stall
    drive(mk(1, 4, 1'b1, 32'h70), 1'b0);
    cycle();
    drive(mk(4, 2, 1'b0, 32'h74), 1'b0);
    #1;
    chk("ar_stall", 128'(bus.stall), 128'(1));
    #1;
    reset = 1'b1;
    #1;
    m_ex  = '0;
    m_cnt = 0;
    chk("ar_cnt", 128'(bus.stall_count), 128'(0));
    chk("ar_idex", 128'(out_bundle()), 128'(0));
    chk("ar_pcwrite", 128'(bus.PCWrite), 128'(1));
    chk("ar_nostall", 128'(bus.stall), 128'(0));
    @(negedge clk);
    reset = 1'b0;
    cycle();
    chk("ar_load", 128'(bus.IDEX_RegisterRs), 128'(4));

    // randomized traffic over a small register window
    for (int n = 0; n < 400; n++) begin
      r      = '0;
      r.rs   = 5'($urandom_range(0, 3));
      r.rt   = 5'($urandom_range(0, 3));
      r.rd   = 5'($urandom_range(0, 31));
      r.d1   = $urandom;
      r.d2   = $urandom;
      r.imm  = $urandom;
      r.rw   = 1'($urandom_range(0, 1));
      r.mr   = 1'($urandom_range(0, 1));
      r.mw   = 1'($urandom_range(0, 1));
      r.m2r  = 1'($urandom_range(0, 1));
      r.rdst = 1'($urandom_range(0, 1));
      r.asrc = 1'($urandom_range(0, 1));
      r.op   = 2'($urandom_range(0, 3));
      drive(r, 1'($urandom_range(0, 1)));
      bus.flush       = ($urandom_range(0, 7) == 0);
      bus.mem_busy    = ($urandom_range(0, 7) == 0);
      bus.sc_load     = ($urandom_range(0, 63) == 0);
      bus.sc_load_val = 16'hFFF0 + 16'($urandom_range(0, 15));
      cycle();
    end
    bus.sc_load  = 1'b0;
    bus.flush    = 1'b0;
    bus.mem_busy = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
